// File: rtl/serv_ibus_mem.sv
// serv_ibus_mem: SERV instruction-bus memory responder with RVC halfword-straddle assembly
module serv_ibus_mem #(
  parameter int    AW          = 8,
  parameter int    WAIT_STATES = 0,
  parameter string MEMFILE     = ""
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic [31:0]   i_ibus_adr,
  input  logic          i_ibus_cyc,
  output logic [31:0]   o_ibus_rdt,
  output logic          o_ibus_ack,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_adr,
  input  logic [31:0]   i_ld_dat
);
  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, ACK} state_t;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  state_t        state_q;
  logic [31:0]   mem [2**AW];
  logic [31:0]   rd_q;
  logic [15:0]   hold_q;
  logic [3:0]    cnt_q;
  logic          a1_q;
  logic [AW-1:0] wa;
  logic [AW-1:0] rd_adr;
  logic          rd_en;
  logic          unused_adr;
  assign wa         = i_ibus_adr[AW+1:2];
  assign unused_adr = ^{i_ibus_adr[31:AW+2], i_ibus_adr[0]};
  assign rd_en  = i_ibus_cyc && (state_q == IDLE || (state_q == RD_LO && cnt_q == 4'd0 && a1_q));
  assign rd_adr = (state_q == IDLE) ? wa : wa + 1'b1;
  assign o_ibus_ack = (state_q == ACK);
  assign o_ibus_rdt = o_ibus_ack ? (a1_q ? {rd_q[15:0], hold_q} : rd_q) : 32'd0;
  always_ff @(posedge clk) begin
    if (i_ld_en) mem[i_ld_adr] <= i_ld_dat;
    if (rd_en) rd_q <= mem[rd_adr];
  end
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hold_q  <= 16'd0;
      a1_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_ibus_cyc) begin
          state_q <= RD_LO;
          cnt_q   <= WS;
          a1_q    <= i_ibus_adr[1];
        end
        RD_LO: if (!i_ibus_cyc) begin
          state_q <= IDLE;
          hold_q  <= 16'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else if (a1_q) begin
          hold_q  <= rd_q[31:16];
          cnt_q   <= WS;
          state_q <= RD_HI;
        end else begin
          state_q <= ACK;
        end
        RD_HI: if (!i_ibus_cyc) begin
          state_q <= IDLE;
          hold_q  <= 16'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          state_q <= ACK;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serv_ibus_mem.sv
// tb_serv_ibus_mem: directed bench over three instances (0, 2 and 3 wait states) sharing load port
module tb_serv_ibus_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = 32'd0;
  logic [2:0]  cyc = 3'b000;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_adr = 8'd0;
  logic [31:0] ld_dat = 32'd0;
  logic [31:0] rdt [3];
  logic [2:0]  ack;
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  serv_ibus_mem #(.AW(8), .WAIT_STATES(0)) u0 (.clk(clk), .i_rst(rst), .i_ibus_adr(adr), .i_ibus_cyc(cyc[0]),
    .o_ibus_rdt(rdt[0]), .o_ibus_ack(ack[0]), .i_ld_en(ld_en), .i_ld_adr(ld_adr), .i_ld_dat(ld_dat));
  serv_ibus_mem #(.AW(8), .WAIT_STATES(2)) u2 (.clk(clk), .i_rst(rst), .i_ibus_adr(adr), .i_ibus_cyc(cyc[1]),
    .o_ibus_rdt(rdt[1]), .o_ibus_ack(ack[1]), .i_ld_en(ld_en), .i_ld_adr(ld_adr), .i_ld_dat(ld_dat));
  serv_ibus_mem #(.AW(8), .WAIT_STATES(3)) u3 (.clk(clk), .i_rst(rst), .i_ibus_adr(adr), .i_ibus_cyc(cyc[2]),
    .o_ibus_rdt(rdt[2]), .o_ibus_ack(ack[2]), .i_ld_en(ld_en), .i_ld_adr(ld_adr), .i_ld_dat(ld_dat));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_adr = a; ld_dat = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask
  // lat is the index of the edge after which ack is high, E0 being the first edge with cyc sampled high
  task automatic fetch(input string tag, input int k, input logic [31:0] a, input logic [31:0] exp, input int lat);
    int n;
    bit got;
    @(negedge clk);
    adr = a; cyc[k] = 1'b1;
    n = -1; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ack[k]) got = 1'b1;
      else if (n == 0) chk({tag, "_rdt_idle"}, rdt[k], 32'd0);
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_rdt"}, rdt[k], exp);
    @(negedge clk);
    cyc[k] = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ack_once"}, 32'(ack[k]), 32'd0);
    chk({tag, "_rdt_after"}, rdt[k], 32'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdt0", rdt[0], 32'd0);
    chk("rst_rdt3", rdt[2], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    load(8'd4, 32'h00A00093);
    fetch("al0", 0, 32'h10, 32'h00A00093, 1);
    load(8'd4, 32'h1234ABCD);
    load(8'd5, 32'h5678EF01);
    fetch("mis0", 0, 32'h12, 32'hEF011234, 2);
    load(8'd255, 32'hAAAABBBB);
    load(8'd0, 32'hCCCCDDDD);
    fetch("wrap3", 2, 32'h3FE, 32'hDDDDAAAA, 8);
    fetch("top3", 2, 32'h3FC, 32'hAAAABBBB, 4);
    // reset while the misaligned fetch sits in RD_HI (after E5)
    @(negedge clk);
    adr = 32'h12; cyc[2] = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("rsthi_noack_pre", 32'(ack[2]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cyc[2] = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      chk("rsthi_noack", 32'(ack[2]), 32'd0);
    end
    fetch("after_rst", 2, 32'h10, 32'h1234ABCD, 4);
    // abort in RD_LO with two wait states
    @(negedge clk);
    adr = 32'h10; cyc[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc[1] = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_noack", 32'(ack[1]), 32'd0);
    end
    // cyc held high across two fetches: acks after E3 and E8
    @(negedge clk);
    adr = 32'h10; cyc[1] = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      @(posedge clk); #1;
      chk("cont_ack", 32'(ack[1]), 32'(n == 3 || n == 8));
      if (ack[1]) chk("cont_rdt", rdt[1], 32'h1234ABCD);
    end
    @(negedge clk);
    cyc[1] = 1'b0;
    repeat (3) @(posedge clk);
    // load and fetch to the same word at E0: old data returned
    load(8'd8, 32'h11112222);
    @(negedge clk);
    adr = 32'h20; cyc[0] = 1'b1;
    ld_en = 1'b1; ld_adr = 8'd8; ld_dat = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
    @(posedge clk); #1;
    chk("coll_ack", 32'(ack[0]), 32'd1);
    chk("coll_rdt", rdt[0], 32'h11112222);
    @(negedge clk);
    cyc[0] = 1'b0;
    @(posedge clk);
    fetch("refetch", 0, 32'h20, 32'hDEADBEEF, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
